branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-side branch predictor and mispredict detector, complementing the execute-stage branch resolver. A direct-mapped branch target buffer (BTB) with 2-bit saturating counters gives a combinational taken/target prediction for the current fetch PC. Resolved outcomes from the execute stage train the table and raise a registered mispredict/redirect toward the PC mux. Two performance counters track resolved branches and mispredicts.

## Interface
Parameters:
- `ENTRIES`, 16: number of BTB entries; power of two, ≥ 2.
- `IDX_W`, $clog2(ENTRIES): index width.

Ports:
- `clk`: in, 1, single clock; all state updates on the rising edge.
- `reset`: in, 1, synchronous, active-high.
- `pc_if`: in, 32 (`word`), fetch PC to look up.
- `pred_take`: out, 1, combinational taken prediction for `pc_if`.
- `pred_target`: out, 32, combinational predicted target; 0 when `pred_take`=0.
- `upd_valid`: in, 1, one resolved control-flow instruction this cycle.
- `upd_pc`: in, 32, PC of the resolved instruction.
- `upd_taken`: in, 1, actual outcome (branch resolver output selects the branch target).
- `upd_target`: in, 32, actual taken target.
- `upd_pred_take`: in, 1, prediction that travelled down the pipe with the instruction.
- `upd_pred_target`: in, 32, predicted target that travelled with it.
- `mispredict`: out, 1, registered; one-cycle pulse.
- `redirect_pc`: out, 32, registered correct next PC; valid while `mispredict`=1.
- `branch_cnt`: out, 32, resolved-event counter.
- `miss_cnt`: out, 32, mispredict counter.

## Operation
- Index = `pc[IDX_W+1:2]`; tag = `pc[31:IDX_W+2]`. `pc[1:0]` is ignored.
- Each entry holds `valid`, `tag`, `target[31:0]` and `ctr[1:0]`.
- Counter encoding: 0 = strongly not-taken, 1 = weakly not-taken, 2 = weakly taken, 3 = strongly taken.
- Lookup: `hit` = valid && tag match. `pred_take` = hit && `ctr[1]`. `pred_target` = `pred_take` ? target : 0.
- Update, when `upd_valid`=1, at the entry indexed by `upd_pc`:
  - Hit and taken: `ctr` = min(ctr+1, 3); target ← `upd_target`.
  - Hit and not taken: `ctr` = max(ctr−1, 0); target unchanged.
  - Miss and taken: allocate. valid=1, tag/target written, `ctr`=2. Replaces any aliasing entry.
  - Miss and not taken: no change.
- Mispredict condition: `upd_taken` ≠ `upd_pred_take`, or (`upd_taken` && `upd_target` ≠ `upd_pred_target`).
- Redirect: `redirect_pc` = `upd_taken` ? `upd_target` : `upd_pc`+4. The +4 is modulo 2^32, so 0xFFFF_FFFC wraps to 0.
- Counters, per `upd_valid`=1 event:
  - `branch_cnt` += 1.
  - `miss_cnt` += 1 if the mispredict condition holds.
  - Both wrap modulo 2^32.

## Timing
- Lookup is combinational, zero latency from `pc_if`.
- Table write takes effect at the rising edge where `upd_valid`=1.
- Same-cycle lookup and update of the same index: lookup returns pre-update contents. There is no bypass.
- `mispredict` and `redirect_pc` are registered. They appear exactly one cycle after the `upd_valid` cycle and hold for one cycle only.
  - Back-to-back `upd_valid` events each produce their own pulse.
  - With `upd_valid`=0, `mispredict`=0 and `redirect_pc` holds its last value.
- Reset, synchronous:
  - All `valid`=0, all `ctr`=1.
  - `mispredict`=0, `redirect_pc`=0, `branch_cnt`=0, `miss_cnt`=0.
  - Consequently `pred_take`=0 and `pred_target`=0 for any `pc_if` in the cycle after reset.
- Reset wins over a simultaneous `upd_valid`: no table or counter update, no pulse.
- `upd_*` inputs other than `upd_valid` are don't-care when `upd_valid`=0.

## Test plan
1. Reset, then sweep `pc_if` over 0x0–0x3C → `pred_take`=0 and `pred_target`=0 everywhere; all counters read 0.
2. Allocate then hit:
   - `upd_valid` with `upd_pc`=0x100, taken, target 0x200, predicted not-taken → next cycle `mispredict`=1, `redirect_pc`=0x200, `miss_cnt`=1.
   - Then `pc_if`=0x100 → `pred_take`=1, `pred_target`=0x200.
3. Counter saturation and fall, on entry 0x100 starting at `ctr`=2:
   - 3× taken updates → `ctr`=3 and stays 3.
   - 2× not-taken → `ctr`=1, so `pred_take`=0 for 0x100.
   - 2 more not-taken → `ctr`=0, entry still valid.
4. Alias and target change, with ENTRIES=16:
   - Update 0x140 taken → target 0x300; replaces 0x100 (same index). `pc_if`=0x100 → `pred_take`=0.
   - Taken update of 0x140 with `upd_target` 0x400 ≠ `upd_pred_target` 0x300 → `mispredict`=1, `redirect_pc`=0x400.
5. Not-taken mispredict with wrap: `upd_pc`=0xFFFF_FFFC, not taken, predicted taken → `redirect_pc`=0x0. A correct prediction in the following cycle → `mispredict`=0, `branch_cnt`=2, `miss_cnt`=1.
6. Simultaneous events:
   - Lookup and update of the same index in one cycle → old prediction observed; new value visible the next cycle.
   - `reset` asserted with `upd_valid`=1 → no pulse, all counters 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit saturating counters,
// trained by resolved branches, plus a registered mispredict/redirect and perf counters.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_if,
    output logic        pred_take,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_take,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] miss_cnt
);

    localparam int unsigned TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] if_idx, upd_idx;
    logic [TAG_W-1:0] if_tag, upd_tag;
    logic             if_hit, upd_hit;

    logic             wr_en;
    logic [1:0]       wr_ctr;
    logic [31:0]      wr_target;
    logic             miss_cond;
    logic [31:0]      redirect_d;

    logic             mispredict_q;
    logic [31:0]      redirect_q;
    logic [31:0]      branch_cnt_q;
    logic [31:0]      miss_cnt_q;

    // Byte-offset bits never take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_if[1:0], upd_pc[1:0]};

    assign if_idx  = pc_if[IDX_W+1:2];
    assign if_tag  = pc_if[31:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[31:IDX_W+2];

    // Lookup sees pre-update contents; there is deliberately no write bypass.
    always_comb begin
        if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_take   = if_hit && ctr_q[if_idx][1];
        pred_target = pred_take ? target_q[if_idx] : 32'd0;
    end

    always_comb begin
        upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        wr_en     = 1'b0;
        wr_ctr    = ctr_q[upd_idx];
        wr_target = target_q[upd_idx];
        if (upd_valid) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    wr_ctr    = (ctr_q[upd_idx] == 2'd3) ? 2'd3 : ctr_q[upd_idx] + 2'd1;
                    wr_target = upd_target;
                end else begin
                    wr_ctr = (ctr_q[upd_idx] == 2'd0) ? 2'd0 : ctr_q[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Allocation evicts whatever aliases into this slot.
                wr_en     = 1'b1;
                wr_ctr    = 2'd2;
                wr_target = upd_target;
            end
        end
    end

    always_comb begin
        miss_cond  = (upd_taken != upd_pred_take) ||
                     (upd_taken && (upd_target != upd_pred_target));
        redirect_d = upd_taken ? upd_target : upd_pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'd1;
            end
        end else if (wr_en) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= wr_target;
            ctr_q[upd_idx]    <= wr_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict_q <= 1'b0;
            redirect_q   <= 32'd0;
            branch_cnt_q <= 32'd0;
            miss_cnt_q   <= 32'd0;
        end else begin
            mispredict_q <= upd_valid && miss_cond;
            if (upd_valid) begin
                redirect_q   <= redirect_d;
                branch_cnt_q <= branch_cnt_q + 32'd1;
                if (miss_cond) begin
                    miss_cnt_q <= miss_cnt_q + 32'd1;
                end
            end
        end
    end

    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_q;
    assign branch_cnt  = branch_cnt_q;
    assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16).
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] pc_if;
    logic        pred_take;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_take;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] miss_cnt;

    int checks;
    int failures;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_if           (pc_if),
        .pred_take       (pred_take),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_take   (upd_pred_take),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .branch_cnt      (branch_cnt),
        .miss_cnt        (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_take,
                        input logic [31:0] exp_target);
        pc_if = pc;
        #1;
        check({tag, ".take"}, {31'd0, pred_take}, {31'd0, exp_take});
        check({tag, ".target"}, pred_target, exp_target);
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                             input logic ptake, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = taken;
        upd_target      = tgt;
        upd_pred_take   = ptake;
        upd_pred_target = ptgt;
    endtask

    task automatic finish_upd(input string tag, input logic exp_mis, input logic [31:0] exp_redir);
        step();
        upd_valid = 1'b0;
        check({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, exp_mis});
        check({tag, ".redirect"}, redirect_pc, exp_redir);
    endtask

    task automatic resolve(input string tag, input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic ptake, input logic [31:0] ptgt,
                           input logic exp_mis, input logic [31:0] exp_redir);
        drive_upd(pc, taken, tgt, ptake, ptgt);
        finish_upd(tag, exp_mis, exp_redir);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        pc_if           = 32'd0;
        upd_valid       = 1'b0;
        upd_pc          = 32'd0;
        upd_taken       = 1'b0;
        upd_target      = 32'd0;
        upd_pred_take   = 1'b0;
        upd_pred_target = 32'd0;
        step();
        step();
        reset = 1'b0;

        // 1: empty table after reset
        check("rst.mispredict", {31'd0, mispredict}, 32'd0);
        check("rst.redirect", redirect_pc, 32'd0);
        check("rst.branch_cnt", branch_cnt, 32'd0);
        check("rst.miss_cnt", miss_cnt, 32'd0);
        for (int a = 0; a <= 32'h3C; a += 4) begin
            look("rst.sweep", a, 1'b0, 32'd0);
        end
        step();

        // 2: allocate 0x100 -> 0x200, predicted not-taken
        resolve("alloc", 32'h100, 1'b1, 32'h200, 1'b0, 32'd0, 1'b1, 32'h200);
        check("alloc.miss_cnt", miss_cnt, 32'd1);
        check("alloc.branch_cnt", branch_cnt, 32'd1);
        look("alloc.hit", 32'h100, 1'b1, 32'h200);
        step();
        check("idle.mispredict", {31'd0, mispredict}, 32'd0);
        check("idle.redirect_hold", redirect_pc, 32'h200);

        // 3: saturate at 3, then fall to 0 while staying valid
        for (int k = 0; k < 3; k++) begin
            resolve("sat.up", 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200);
        end
        resolve("sat.dn1", 32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h104);
        look("sat.ctr2", 32'h100, 1'b1, 32'h200);
        resolve("sat.dn2", 32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h104);
        look("sat.ctr1", 32'h100, 1'b0, 32'd0);
        resolve("sat.dn3", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h104);
        resolve("sat.dn4", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h104);
        // From ctr=0 one taken reaches 1 (no take); a wrapped or dropped entry would predict taken
        resolve("sat.up_from0", 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
        look("sat.ctr1_again", 32'h100, 1'b0, 32'd0);
        resolve("sat.up_to2", 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
        look("sat.ctr2_again", 32'h100, 1'b1, 32'h200);
        check("sat.branch_cnt", branch_cnt, 32'd10);
        check("sat.miss_cnt", miss_cnt, 32'd5);

        // 4: alias eviction and target change
        resolve("alias.alloc", 32'h140, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 32'h300);
        look("alias.old_gone", 32'h100, 1'b0, 32'd0);
        look("alias.new", 32'h140, 1'b1, 32'h300);
        resolve("alias.tgt", 32'h140, 1'b1, 32'h400, 1'b1, 32'h300, 1'b1, 32'h400);
        look("alias.newtgt", 32'h140, 1'b1, 32'h400);
        check("alias.branch_cnt", branch_cnt, 32'd12);
        check("alias.miss_cnt", miss_cnt, 32'd7);

        // 5: wrap of pc+4, back-to-back with a correct prediction
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2.branch_cnt", branch_cnt, 32'd0);
        look("rst2.cleared", 32'h140, 1'b0, 32'd0);
        drive_upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h1234);
        step();
        check("wrap.mispredict", {31'd0, mispredict}, 32'd1);
        check("wrap.redirect", redirect_pc, 32'h0);
        drive_upd(32'h8, 1'b0, 32'h0, 1'b0, 32'h0);
        finish_upd("b2b", 1'b0, 32'hC);
        check("b2b.branch_cnt", branch_cnt, 32'd2);
        check("b2b.miss_cnt", miss_cnt, 32'd1);

        // 6a: same-cycle lookup and update of one index
        drive_upd(32'h180, 1'b1, 32'h500, 1'b0, 32'h0);
        look("same.pre_alloc", 32'h180, 1'b0, 32'd0);
        finish_upd("same.alloc", 1'b1, 32'h500);
        look("same.post_alloc", 32'h180, 1'b1, 32'h500);
        drive_upd(32'h180, 1'b0, 32'h0, 1'b1, 32'h500);
        look("same.pre_dec", 32'h180, 1'b1, 32'h500);
        finish_upd("same.dec", 1'b1, 32'h184);
        look("same.post_dec", 32'h180, 1'b0, 32'd0);
        check("same.miss_cnt", miss_cnt, 32'd3);

        // 6b: reset beats a simultaneous update
        step();
        reset = 1'b1;
        drive_upd(32'h1C0, 1'b1, 32'h900, 1'b0, 32'h0);
        step();
        reset     = 1'b0;
        upd_valid = 1'b0;
        check("rstupd.mispredict", {31'd0, mispredict}, 32'd0);
        check("rstupd.redirect", redirect_pc, 32'd0);
        check("rstupd.branch_cnt", branch_cnt, 32'd0);
        check("rstupd.miss_cnt", miss_cnt, 32'd0);
        look("rstupd.no_alloc", 32'h1C0, 1'b0, 32'd0);
        step();
        check("rstupd.no_pulse", {31'd0, mispredict}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
